rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Each cycle in IDLE it selects the next requester after the last owner, using a rotated request vector fed to an 8-bit lowest-index-first priority encoder.
- It holds the grant until the owner releases, or until a hold timeout forcibly revokes it.
- Sits between request sources and a shared datapath; grant_id drives the datapath mux select.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/prio_enc8.sv | 19 +
 rtl/rr_arbiter8.sv | 77 +++++++
 tb/tb_rr_arbiter8.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and rotate helpers for the 8-way arbiter
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {IDLE, BUSY} state_t;

   function automatic logic [N_REQ-1:0] rotl8(input logic [N_REQ-1:0] v, input logic [ID_W-1:0] amt);
      logic [2*N_REQ-1:0] tmp;
      tmp = {v, v} << amt;
      return tmp[2*N_REQ-1:N_REQ];
   endfunction

   function automatic logic [N_REQ-1:0] rotr8(input logic [N_REQ-1:0] v, input logic [ID_W-1:0] amt);
      logic [2*N_REQ-1:0] tmp;
      tmp = {v, v} >> amt;
      return tmp[N_REQ-1:0];
   endfunction

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - lowest-index-first priority encoder over 8 bits
module prio_enc8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] vec,
   output logic [ID_W-1:0]  idx,
   output logic             valid
);

   always_comb begin
      idx   = '0;
      valid = |vec;
      // scan downward so the lowest set bit is the last one written
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold timeout
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   logic [ID_W-1:0]  last_id;
   logic [CNT_W-1:0] hold_cnt;
   logic [ID_W-1:0]  shift;
   logic [N_REQ-1:0] req_rot;
   logic [ID_W-1:0]  enc_idx;
   logic             enc_valid;
   logic [ID_W-1:0]  winner;

   // bring last_id+1 down to bit 0 so the encoder scans in round-robin order
   assign shift   = last_id + 3'd1;
   assign req_rot = rotr8(req, shift);
   assign winner  = enc_idx + shift;

   prio_enc8 u_enc (
      .vec   (req_rot),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_id     <= 3'd7;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (enc_valid) begin
                  grant       <= N_REQ'(1) << winner;
                  grant_id    <= winner;
                  grant_valid <= 1'b1;
                  hold_cnt    <= '0;
                  last_id     <= winner;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               // release takes precedence over an expiring hold
               if (!req[grant_id] || hold_cnt == HOLD_LAST) begin
                  grant       <= '0;
                  grant_id    <= '0;
                  grant_valid <= 1'b0;
                  timeout     <= req[grant_id];
                  state       <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - randomized and directed bench for rr_arbiter8
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // reference model: owner index (-1 = none), last owner, cycles granted so far
   int m_owner = -1;
   int m_last  = 7;
   int m_held  = 0;
   bit m_tout  = 1'b0;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_last  = 7;
         m_held  = 0;
         m_tout  = 1'b0;
      end else begin
         m_tout = 1'b0;
         if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
               if (m_owner < 0 && req[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
            end
            if (m_owner >= 0) begin
               m_last = m_owner;
               m_held = 1;
            end
         end else if (!req[m_owner]) begin
            m_owner = -1;
         end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_tout  = 1'b1;
         end else begin
            m_held++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         chk("model_grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
         chk("model_grant_valid", grant_valid, m_owner >= 0);
         chk("model_timeout", timeout, m_tout);
      end
   end

   task automatic drive(input logic [7:0] r, input int n);
      req = r;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 8'h00);
      chk("rst_grant_id", grant_id, 3'd0);
      chk("rst_grant_valid", grant_valid, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      drive(8'h00, 1);

      drive(8'hA4, 1);
      chk("first_grant", grant, 8'h04);
      chk("first_grant_id", grant_id, 3'd2);
      chk("first_valid", grant_valid, 1'b1);
      chk("first_timeout", timeout, 1'b0);
      drive(8'hA0, 1);
      chk("release_grant", grant, 8'h00);
      chk("release_valid", grant_valid, 1'b0);
      drive(8'hA0, 1);
      chk("rotate_id", grant_id, 3'd5);
      drive(8'h00, 2);

      drive(8'h80, 1);
      chk("pick7_id", grant_id, 3'd7);
      drive(8'h00, 1);
      drive(8'h81, 1);
      chk("wrap_id", grant_id, 3'd0);
      drive(8'h80, 1);
      chk("wrap_gap", grant_valid, 1'b0);
      drive(8'h80, 1);
      chk("wrap_next_id", grant_id, 3'd7);
      drive(8'h00, 2);

      req = 8'h08;
      for (int i = 0; i < MAX_HOLD; i++) begin
         @(negedge clk);
         chk("hold_grant", grant, 8'h08);
      end
      @(negedge clk);
      chk("revoke_timeout", timeout, 1'b1);
      chk("revoke_grant", grant, 8'h00);
      @(negedge clk);
      chk("regrant_id", grant_id, 3'd3);
      chk("regrant_timeout", timeout, 1'b0);
      drive(8'h08, 8);
      drive(8'h00, 2);

      drive(8'h09, 20);
      drive(8'h00, 2);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req = 8'($urandom);
         else if ($urandom_range(0, 7) == 0) req = 8'($urandom) & 8'($urandom);
         @(negedge clk);
      end
      drive(8'h00, 2);

      drive(8'h20, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_grant", grant, 8'h00);
      chk("async_valid", grant_valid, 1'b0);
      chk("async_timeout", timeout, 1'b0);
      @(negedge clk);
      req   = 8'hA0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_id", grant_id, 3'd5);
      chk("post_rst_valid", grant_valid, 1'b1);
      drive(8'h00, 2);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
